// File: rtl/pusch_re_demapper.sv
// PUSCH receive RE demapper: steers allocated FFT bins to the data or DMRS outputs and tracks symbol/slot boundaries.
// Optional PUSCH_RE_DEMAP_ADD_DMRS_EN adds symbol 11 as an extra DMRS position.
module pusch_re_demapper #(
  parameter int WIDTH     = 18,
  parameter int NFFT_LOG2 = 11,
  parameter int N_SYMB    = 14
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    enable_i,
  input  logic [6:0]              n_rb_i,
  input  logic [NFFT_LOG2-1:0]    n_sc_i,
  input  logic [3:0]              dmrs_symbol_i,
  input  logic signed [WIDTH-1:0] din_r_i,
  input  logic signed [WIDTH-1:0] din_i_i,
  input  logic                    din_valid_i,
  output logic signed [WIDTH-1:0] data_r_o,
  output logic signed [WIDTH-1:0] data_i_o,
  output logic                    data_valid_o,
  output logic signed [WIDTH-1:0] dmrs_r_o,
  output logic signed [WIDTH-1:0] dmrs_i_o,
  output logic                    dmrs_valid_o,
  output logic [3:0]              symbol_idx_o,
  output logic                    slot_done_o,
  output logic                    cfg_err_o
);

  localparam int AW = NFFT_LOG2 + 1;
  // Wide enough that n_sc + 12*n_rb can never wrap during the range check.
  localparam int CW = NFFT_LOG2 + 8;
  localparam logic [CW-1:0] NBINS = CW'(1) << NFFT_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                  state_q;
  logic [NFFT_LOG2-1:0]    n_sc_q;
  logic [AW-1:0]           alloc_end_q;
  logic [3:0]              dmrs_sym_q;
  logic [NFFT_LOG2-1:0]    bin_cnt_q;
  logic [3:0]              sym_cnt_q;
  logic                    s1_vld_q;
  logic                    s1_alloc_q;
  logic                    s1_dmrs_q;
  logic signed [WIDTH-1:0] s1_r_q;
  logic signed [WIDTH-1:0] s1_i_q;
  logic [3:0]              s1_sym_q;
  logic                    done_d1_q;

  logic [CW-1:0] cfg_end;
  logic [AW-1:0] alloc_end_d;
  logic          cfg_bad;
  logic          accept;
  logic          in_alloc;
  logic          is_dmrs_sym;
  logic          bin_last;
  logic          sym_last;
  logic          s1_data;
  logic          s1_dmrs;

  assign cfg_end     = CW'(n_sc_i) + CW'(n_rb_i) * CW'(12);
  assign alloc_end_d = cfg_end[AW-1:0];
  assign cfg_bad     = (n_rb_i == 7'd0) || (cfg_end > NBINS) || (dmrs_symbol_i >= 4'(N_SYMB));

  assign accept   = (state_q == S_RUN) && din_valid_i;
  assign in_alloc = (bin_cnt_q >= n_sc_q) && (AW'(bin_cnt_q) < alloc_end_q);
  assign bin_last = (bin_cnt_q == {NFFT_LOG2{1'b1}});
  assign sym_last = (sym_cnt_q == 4'(N_SYMB - 1));

`ifdef PUSCH_RE_DEMAP_ADD_DMRS_EN
  assign is_dmrs_sym = (sym_cnt_q == dmrs_sym_q) || (sym_cnt_q == 4'd11);
`else
  assign is_dmrs_sym = (sym_cnt_q == dmrs_sym_q);
`endif

  assign s1_data = s1_vld_q && s1_alloc_q && !s1_dmrs_q;
  assign s1_dmrs = s1_vld_q && s1_alloc_q && s1_dmrs_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      n_sc_q       <= '0;
      alloc_end_q  <= '0;
      dmrs_sym_q   <= '0;
      bin_cnt_q    <= '0;
      sym_cnt_q    <= '0;
      s1_vld_q     <= 1'b0;
      s1_alloc_q   <= 1'b0;
      s1_dmrs_q    <= 1'b0;
      s1_r_q       <= '0;
      s1_i_q       <= '0;
      s1_sym_q     <= '0;
      done_d1_q    <= 1'b0;
      data_r_o     <= '0;
      data_i_o     <= '0;
      data_valid_o <= 1'b0;
      dmrs_r_o     <= '0;
      dmrs_i_o     <= '0;
      dmrs_valid_o <= 1'b0;
      symbol_idx_o <= '0;
      slot_done_o  <= 1'b0;
      cfg_err_o    <= 1'b0;
    end else begin
      // Capture stage: steering decision travels with the sample.
      s1_vld_q <= accept;
      if (accept) begin
        s1_alloc_q <= in_alloc;
        s1_dmrs_q  <= is_dmrs_sym;
        s1_r_q     <= din_r_i;
        s1_i_q     <= din_i_i;
        s1_sym_q   <= sym_cnt_q;
      end

      data_valid_o <= s1_data;
      dmrs_valid_o <= s1_dmrs;
      if (s1_vld_q) symbol_idx_o <= s1_sym_q;
      if (s1_data) begin
        data_r_o <= s1_r_q;
        data_i_o <= s1_i_q;
      end
      if (s1_dmrs) begin
        dmrs_r_o <= s1_r_q;
        dmrs_i_o <= s1_i_q;
      end

      // Slot-done trails DONE by two edges so it lands after the final RE output.
      done_d1_q   <= (state_q == S_DONE);
      slot_done_o <= done_d1_q;

      case (state_q)
        S_IDLE: begin
          if (enable_i) begin
            if (cfg_bad) begin
              cfg_err_o <= 1'b1;
            end else begin
              cfg_err_o   <= 1'b0;
              n_sc_q      <= n_sc_i;
              alloc_end_q <= alloc_end_d;
              dmrs_sym_q  <= dmrs_symbol_i;
              bin_cnt_q   <= '0;
              sym_cnt_q   <= '0;
              state_q     <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (din_valid_i) begin
            bin_cnt_q <= bin_cnt_q + NFFT_LOG2'(1);
            if (bin_last) begin
              sym_cnt_q <= sym_cnt_q + 4'd1;
              if (sym_last) state_q <= S_DONE;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pusch_re_demapper.sv
// Directed bench for pusch_re_demapper; runs with a 128-bin FFT so complete slots stay short.
// Compile with or without PUSCH_RE_DEMAP_ADD_DMRS_EN; expected counts follow the macro.
module tb_pusch_re_demapper;
  localparam int W  = 18;
  localparam int NL = 7;
  localparam int NS = 14;
  localparam int NB = 1 << NL;

`ifdef PUSCH_RE_DEMAP_ADD_DMRS_EN
  localparam int ADD = 1;
`else
  localparam int ADD = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [6:0]    n_rb;
  logic [NL-1:0] n_sc;
  logic [3:0]    dmrs_sym;
  logic [W-1:0]  din_r, din_i;
  logic          din_valid;
  logic [W-1:0]  data_r, data_i, dmrs_r, dmrs_i;
  logic          data_valid, dmrs_valid, slot_done, cfg_err;
  logic [3:0]    symbol_idx;

  always #5 clk = ~clk;

  pusch_re_demapper #(.WIDTH(W), .NFFT_LOG2(NL), .N_SYMB(NS)) dut (
    .clk_i(clk), .reset_i(rst), .enable_i(en),
    .n_rb_i(n_rb), .n_sc_i(n_sc), .dmrs_symbol_i(dmrs_sym),
    .din_r_i(din_r), .din_i_i(din_i), .din_valid_i(din_valid),
    .data_r_o(data_r), .data_i_o(data_i), .data_valid_o(data_valid),
    .dmrs_r_o(dmrs_r), .dmrs_i_o(dmrs_i), .dmrs_valid_o(dmrs_valid),
    .symbol_idx_o(symbol_idx), .slot_done_o(slot_done), .cfg_err_o(cfg_err)
  );

  typedef struct {
    logic         dmrs;
    logic [W-1:0] r;
    logic [W-1:0] i;
    logic [3:0]   sym;
    int           cyc;
  } exp_t;

  typedef struct {
    int rb, sc, ds;
    bit gap, err;
    int ed, em;
  } vec_t;

  exp_t expq[$];
  vec_t tv[8];
  int n_chk = 0, n_fail = 0, cyc = 0;
  int n_data, n_dmrs, n_done, done_cyc, last_acc;
  logic [W-1:0] last_dr, last_di, last_mr, last_mi;
  bit m_run = 0;
  int m_bin, m_sym, m_nsc, m_end, m_dmrs;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (data_valid || dmrs_valid) begin
      check("one_valid", 64'(data_valid & dmrs_valid), 64'd0);
      if (expq.size() == 0) begin
        check("unexpected_re", 64'd1, 64'd0);
      end else begin
        e = expq.pop_front();
        check("re_kind", 64'(dmrs_valid), 64'(e.dmrs));
        check("re_r", 64'(dmrs_valid ? dmrs_r : data_r), 64'(e.r));
        check("re_i", 64'(dmrs_valid ? dmrs_i : data_i), 64'(e.i));
        check("re_sym", 64'(symbol_idx), 64'(e.sym));
        check("re_latency", 64'(cyc), 64'(e.cyc + 1));
        if (data_valid) begin last_dr = e.r; last_di = e.i; end
        else begin last_mr = e.r; last_mi = e.i; end
      end
      if (data_valid) n_data++; else n_dmrs++;
    end
    if (!data_valid) check("data_hold", 64'({data_r, data_i}), 64'({last_dr, last_di}));
    if (!dmrs_valid) check("dmrs_hold", 64'({dmrs_r, dmrs_i}), 64'({last_mr, last_mi}));
    if (slot_done) begin n_done++; done_cyc = cyc; end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // One input slot; the model records what an accepted sample must produce.
  task automatic drive(input bit vld);
    bit dm;
    din_valid = vld;
    din_r = vld ? W'(m_bin) : '1;
    din_i = vld ? W'(m_sym) : '1;
    step();
    if (vld && m_run) begin
      dm = (m_sym == m_dmrs) || (ADD == 1 && m_sym == 11);
      if (m_bin >= m_nsc && m_bin < m_end)
        expq.push_back('{dm, W'(m_bin), W'(m_sym), 4'(m_sym), cyc});
      if (m_bin == NB - 1) begin
        if (m_sym == NS - 1) begin m_run = 0; last_acc = cyc; end
        m_sym++;
        m_bin = 0;
      end else begin
        m_bin++;
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic start(input int rb, input int sc, input int ds, input bit err);
    n_rb = 7'(rb); n_sc = NL'(sc); dmrs_sym = 4'(ds); en = 1'b1;
    step();
    en = 1'b0;
    n_rb = '0; n_sc = '1; dmrs_sym = 4'd13;
    if (!err) begin
      m_run = 1; m_bin = 0; m_sym = 0; m_nsc = sc; m_end = sc + 12 * rb; m_dmrs = ds;
    end
    n_data = 0; n_dmrs = 0; n_done = 0; done_cyc = -1;
  endtask

  task automatic finish_slot(input string tag, input int ed, input int em, input int nd);
    repeat (4) drive(1'b0);
    check({tag, "_pending"}, 64'(expq.size()), 64'd0);
    check({tag, "_data_cnt"}, 64'(n_data), 64'(ed));
    check({tag, "_dmrs_cnt"}, 64'(n_dmrs), 64'(em));
    check({tag, "_done_cnt"}, 64'(n_done), 64'(nd));
    if (nd == 1) check({tag, "_done_time"}, 64'(done_cyc), 64'(last_acc + 2));
  endtask

  task automatic full_slot(input bit gap);
    for (int s = 0; s < NS * NB; s++) begin
      drive(1'b1);
      if (gap) drive(1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tv[0] = '{2, 100, 2, 0, 0, ADD ? 288 : 312, ADD ? 48 : 24};
    tv[1] = '{2, 100, 2, 1, 0, ADD ? 288 : 312, ADD ? 48 : 24};
    tv[2] = '{1, 117, 2, 0, 1, 0, 0};
    tv[3] = '{1, 116, 2, 0, 0, ADD ? 144 : 156, ADD ? 24 : 12};
    tv[4] = '{0,   0, 2, 0, 1, 0, 0};
    tv[5] = '{1,   0, 14, 0, 1, 0, 0};
    tv[6] = '{1,   0, 2, 0, 0, ADD ? 144 : 156, ADD ? 24 : 12};
    tv[7] = '{1,   0, 11, 0, 0, 156, 12};

    rst = 1'b1; en = 1'b0; n_rb = '0; n_sc = '0; dmrs_sym = '0;
    din_r = '0; din_i = '0; din_valid = 1'b0;
    last_dr = '0; last_di = '0; last_mr = '0; last_mi = '0;
    #1;
    check("rst_data_regs", 64'({data_r, data_i, dmrs_r}), 64'd0);
    check("rst_ctrl", 64'({dmrs_i, data_valid, dmrs_valid, symbol_idx, slot_done, cfg_err}), 64'd0);
    repeat (2) step();
    rst = 1'b0;
    repeat (2) step();

    for (int v = 0; v < 8; v++) begin
      start(tv[v].rb, tv[v].sc, tv[v].ds, tv[v].err);
      check($sformatf("v%0d_cfg_err", v), 64'(cfg_err), 64'(tv[v].err));
      if (tv[v].err) repeat (200) drive(1'b1);
      else full_slot(tv[v].gap);
      finish_slot($sformatf("v%0d", v), tv[v].ed, tv[v].em, tv[v].err ? 0 : 1);
    end

    // Reset in the middle of symbol 5 aborts the slot.
    start(2, 100, 2, 0);
    while (!(m_sym == 5 && m_bin == 100)) drive(1'b1);
    rst = 1'b1;
    #1;
    check("abort_data_regs", 64'({data_r, data_i, dmrs_r}), 64'd0);
    check("abort_ctrl", 64'({dmrs_i, data_valid, dmrs_valid, symbol_idx, slot_done, cfg_err}), 64'd0);
    expq.delete();
    m_run = 0;
    last_dr = '0; last_di = '0; last_mr = '0; last_mi = '0;
    n_done = 0;
    repeat (2) step();
    rst = 1'b0;
    repeat (6) drive(1'b1);
    check("abort_no_done", 64'(n_done), 64'd0);
    start(1, 117, 2, 1);
    check("abort_bad_cfg", 64'(cfg_err), 64'd1);
    start(2, 100, 2, 0);
    check("abort_cfg_clear", 64'(cfg_err), 64'd0);
    full_slot(1'b0);
    finish_slot("after_abort", ADD ? 288 : 312, ADD ? 48 : 24, 1);

    // An enable during RUN must not disturb the active allocation.
    start(2, 100, 2, 0);
    for (int s = 0; s < NS * NB; s++) begin
      if (s == 7 * NB) begin
        en = 1'b1; n_sc = NL'(10); n_rb = 7'd5; dmrs_sym = 4'd4;
      end
      drive(1'b1);
      en = 1'b0;
    end
    check("run_en_cfg_err", 64'(cfg_err), 64'd0);
    finish_slot("run_enable", ADD ? 288 : 312, ADD ? 48 : 24, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
